// File: rtl/alu_muldiv_iter_if.sv
// Request/response bundle for the iterative mul/div unit.
// Ports: request (in_valid/in_ready/op/a/b), response (out_valid/out_ready/result/div_zero).
interface alu_muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Ports: clk, rstn (async low), flush (sync abort), bus (slave: op/a/b in, result/div_zero out).
`ifndef XLEN
`define XLEN 32
`endif

module alu_muldiv_iter #(
  parameter int XLEN  = `XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic              clk,
  input logic              rstn,
  input logic              flush,
  alu_muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic              div_zero_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.div_zero  = div_zero_q;

  logic            sa;
  logic            sb;
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  // signed-a: MULH, MULHSU, DIV, REM; signed-b: MULH, DIV, REM
  always_comb begin
    sa = (bus.op == 3'b001) || (bus.op == 3'b010) ||
         (bus.op == 3'b100) || (bus.op == 3'b110);
    sb = (bus.op == 3'b001) || (bus.op == 3'b100) ||
         (bus.op == 3'b110);
    abs_a  = (sa && bus.a[XLEN-1]) ? -bus.a : bus.a;
    abs_b  = (sb && bus.b[XLEN-1]) ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    ovf    = bus.op[2] && !bus.op[0] &&
             (bus.a == MIN_NEG) && (bus.b == '1);
  end

  logic [XLEN:0]     madd;
  logic [XLEN:0]     dtry;
  logic [XLEN:0]     dsub;
  logic [2*XLEN-1:0] acc_nx;

  // acc = {hi, lo}: mul shifts the partial sum down through lo;
  // div shifts the dividend up into the remainder half.
  always_comb begin
    madd = {1'b0, acc[2*XLEN-1:XLEN]} +
           (acc[0] ? {1'b0, mb} : '0);
    dtry = acc[2*XLEN-1:XLEN-1];
    dsub = dtry - {1'b0, mb};
    if (op_q[2]) begin
      if (dtry >= {1'b0, mb})
        acc_nx = {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nx = {dtry[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {madd, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN]
                 : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (1'b1)
      op_q[2] && op_q[1]:
        fix_res = rem;
      op_q[2] && !op_q[1]:
        fix_res = quo;
      !op_q[2] && (op_q[1:0] == 2'b00):
        fix_res = prod[XLEN-1:0];
      !op_q[2] && (op_q[1:0] != 2'b00):
        fix_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mb          <= '0;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      div_zero_q  <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            in_ready_q <= 1'b0;
            if (bus.op[2] && b_zero) begin
              result_q    <= bus.op[1] ? bus.a : '1;
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (ovf) begin
              result_q    <= bus.op[1] ? '0 : bus.a;
              div_zero_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, abs_a};
              mb    <= abs_b;
              neg_q <= (sa && bus.a[XLEN-1]) ^
                       (sb && bus.b[XLEN-1]);
              neg_r <= sa && bus.a[XLEN-1];
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1))
            state <= FIX;
        end
        FIX: begin
          result_q    <= fix_res;
          div_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Randomised + directed bench for alu_muldiv_iter against an arithmetic model.
// Drives the interface as master; clk/rstn/flush driven directly.
module tb_alu_muldiv_iter;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_muldiv_iter_if #(.XLEN(XLEN)) bus ();

  alu_muldiv_iter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
      input logic [2:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] ub64;
    logic [63:0] p;
    int ia;
    int ib;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == MINV && b == 32'hFFFF_FFFF)
      return 1;
    return XLEN + 2;
  endfunction

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int hold,
                        input string tag);
    int edges;
    logic [31:0] r0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    edges = 1;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, ".lat"}, edges, ref_lat(op, a, b));
    check({tag, ".res"}, bus.result, exp);
    check({tag, ".dz"}, bus.div_zero, op[2] && b == 0);
    r0 = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_v"}, bus.out_valid, 1);
      check({tag, ".hold_r"}, bus.result, r0);
      check({tag, ".hold_rdy"}, bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".ack_v"}, bus.out_valid, 0);
    check({tag, ".ack_rdy"}, bus.in_ready, 1);
  endtask

  task automatic start_and_wait(input int n);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.a        = 32'd12345;
    bus.b        = 32'd678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[14];

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;

    dir[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    dir[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    dir[6]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    dir[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    dir[8]  = '{3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF};
    dir[9]  = '{3'd7, 32'h1234, 32'd0, 32'h1234};
    dir[10] = '{3'd4, MINV, 32'hFFFF_FFFF, MINV};
    dir[11] = '{3'd6, MINV, 32'hFFFF_FFFF, 32'd0};
    dir[12] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
    dir[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB};

    #12;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.result", bus.result, 0);
    check("rst.div_zero", bus.div_zero, 0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (dir[i])
      run_op(dir[i].op, dir[i].a, dir[i].b, dir[i].exp,
             (i == 0) ? 5 : 0, $sformatf("dir%0d", i));

    start_and_wait(10);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.v", bus.out_valid, 0);
    check("flush.rdy", bus.in_ready, 1);
    expect_quiet("flush.quiet");

    @(negedge clk);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle.rdy", bus.in_ready, 1);
    expect_quiet("flush_idle.quiet");

    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678,
           ref_res(3'd1, 32'hDEAD_BEEF, 32'h1234_5678),
           0, "pre_rst");
    start_and_wait(10);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst.rdy", bus.in_ready, 1);
    check("arst.v", bus.out_valid, 0);
    check("arst.res", bus.result, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7,
           ref_res(3'd4, 32'hFFFF_FF9C, 32'd7), 0, "post_rst");

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = MINV;
        3: begin a = MINV; b = 32'hFFFF_FFFF; end
        4: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b, ref_res(op, a, b),
             $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
